sm_para_3_drv: RTL

SM_PARA_3_DRV -- requirements
Module: sm_para_3_drv

---
 rtl/sm_para_3_drv.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sm_para_3_drv.sv
// sm_para_3_drv: replays a captured i1/i2 step sequence into an FSM under test, with err-triggered recovery.
// Define SM_DRV_RESP_CNT_EN to build the o1/o2 response counters; otherwise they read 0.
module sm_para_3_drv #(
    parameter int REC_CYC = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [4:0]  seq_len,
    input  logic [15:0] seq_i1,
    input  logic [15:0] seq_i2,
    input  logic        o1,
    input  logic        o2,
    input  logic        err,
    output logic        i1,
    output logic        i2,
    output logic        busy,
    output logic        done,
    output logic [7:0]  err_cnt,
    output logic [7:0]  o1_cnt,
    output logic [7:0]  o2_cnt
);
    typedef enum logic [1:0] {IDLE, DRIVE, RECOVER, DONE} state_t;
    localparam logic [3:0] RC_LOAD = 4'(REC_CYC - 1);
    state_t      state;
    logic [4:0]  len;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [3:0]  idx;
    logic [3:0]  rc;
    logic [4:0]  req_len;
    logic [4:0]  nxt;
    logic        accept;
    assign req_len = seq_len > 5'd16 ? 5'd16 : seq_len;
    assign nxt     = {1'b0, idx} + 5'd1;
    assign accept  = state == IDLE && start;
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            len     <= '0;
            s1      <= '0;
            s2      <= '0;
            idx     <= '0;
            rc      <= '0;
            i1      <= 1'b0;
            i2      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    err_cnt <= '0;
                    len     <= req_len;
                    s1      <= seq_i1;
                    s2      <= seq_i2;
                    idx     <= '0;
                    if (req_len != 5'd0) begin
                        state <= DRIVE;
                        busy  <= 1'b1;
                        i1    <= seq_i1[0];
                        i2    <= seq_i2[0];
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        i1    <= 1'b0;
                        i2    <= 1'b0;
                    end
                end
                DRIVE: if (err) begin
                    err_cnt <= err_cnt + 8'(err_cnt != 8'hff);
                    i1      <= 1'b0;
                    i2      <= 1'b0;
                    rc      <= RC_LOAD;
                    state   <= RECOVER;
                end else if (nxt == len) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    i1    <= 1'b0;
                    i2    <= 1'b0;
                end else begin
                    idx <= nxt[3:0];
                    i1  <= s1[nxt[3:0]];
                    i2  <= s2[nxt[3:0]];
                end
                // The interrupted step is skipped: recovery always resumes at idx+1.
                RECOVER: if (rc != 4'd0) begin
                    rc <= rc - 4'd1;
                end else if (err) begin
                    rc <= RC_LOAD;
                end else if (nxt == len) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= DRIVE;
                    idx   <= nxt[3:0];
                    i1    <= s1[nxt[3:0]];
                    i2    <= s2[nxt[3:0]];
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef SM_DRV_RESP_CNT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o1_cnt <= '0;
            o2_cnt <= '0;
        end else if (accept) begin
            o1_cnt <= '0;
            o2_cnt <= '0;
        end else if (state == DRIVE) begin
            o1_cnt <= o1_cnt + 8'(o1 && o1_cnt != 8'hff);
            o2_cnt <= o2_cnt + 8'(o2 && o2_cnt != 8'hff);
        end
    end
`else
    logic unused_resp;
    assign unused_resp = o1 ^ o2 ^ accept;
    assign o1_cnt = '0;
    assign o2_cnt = '0;
`endif
endmodule
